muldiv_unit: RTL and testbench

//  Iterative, parametrised multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS core.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_sign_fix.sv | 12 +
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: opcodes and FSM states.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5,
        NOP   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: operand abs on load, result sign fix at finish.
module muldiv_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] mag,
    input  logic         neg,
    output logic [W-1:0] res_c
);

    assign res_c = neg ? (~mag + W'(1)) : mag;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair; shift-add multiply, restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    md_state_e        state;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             dz_pend;

    logic             signed_op_c;
    logic             sa_c;
    logic             sb_c;
    logic [WIDTH-1:0] a_abs_c;
    logic [WIDTH-1:0] b_abs_c;
    logic [ACC_W-1:0] prod_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_diff_c;
    logic [ACC_W-1:0] acc_step_c;

    assign signed_op_c = (op == MULT) || (op == DIV);
    assign sa_c        = signed_op_c & a[WIDTH-1];
    assign sb_c        = signed_op_c & b[WIDTH-1];

    muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.mag(a),   .neg(sa_c), .res_c(a_abs_c));
    muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.mag(b),   .neg(sb_c), .res_c(b_abs_c));
    muldiv_sign_fix #(.W(ACC_W)) u_fix_p (.mag(acc), .neg(neg_lo), .res_c(prod_c));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_q (.mag(acc[WIDTH-1:0]),     .neg(neg_lo), .res_c(quo_c));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_r (.mag(acc[ACC_W-1:WIDTH]), .neg(neg_hi), .res_c(rem_c));

    // One radix-2 step: acc = {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum_c  = {1'b0, acc[ACC_W-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_diff_c = acc[ACC_W-1:WIDTH-1] - {1'b0, opnd};
        acc_step_c = {mul_sum_c, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff_c[WIDTH]) begin
                acc_step_c = {div_diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_c = {acc[ACC_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz_pend  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MTHI: begin
                                hi       <= a;
                                done     <= 1'b1;
                                div_zero <= 1'b0;
                            end
                            MTLO: begin
                                lo       <= a;
                                done     <= 1'b1;
                                div_zero <= 1'b0;
                            end
                            MULT, MULTU: begin
                                acc      <= {{WIDTH{1'b0}}, b_abs_c};
                                opnd     <= a_abs_c;
                                is_div   <= 1'b0;
                                neg_lo   <= sa_c ^ sb_c;
                                neg_hi   <= 1'b0;
                                dz_pend  <= 1'b0;
                                cnt      <= '0;
                                busy     <= 1'b1;
                                div_zero <= 1'b0;
                                state    <= RUN;
                            end
                            DIV, DIVU: begin
                                // Divide by zero keeps an all-ones quotient regardless of signs
                                acc      <= {{WIDTH{1'b0}}, a_abs_c};
                                opnd     <= b_abs_c;
                                is_div   <= 1'b1;
                                neg_lo   <= (sa_c ^ sb_c) & (b != '0);
                                neg_hi   <= sa_c;
                                dz_pend  <= (b == '0);
                                cnt      <= '0;
                                busy     <= 1'b1;
                                div_zero <= 1'b0;
                                state    <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= acc_step_c;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!flush) begin
                        if (is_div) begin
                            lo <= quo_c;
                            hi <= rem_c;
                        end else begin
                            lo <= prod_c[WIDTH-1:0];
                            hi <= prod_c[ACC_W-1:WIDTH];
                        end
                        div_zero <= dz_pend;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits at a negedge. lat = edges from accept edge to the edge that raised done (0 = timeout).
    task automatic run_op(input md_op_e o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcyc, output logic dz1, output logic partial);
        logic [31:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        lat = 0; bcyc = 0; dz1 = 1'bx; partial = 1'b0;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 1) dz1 = div_zero;
            if (busy) bcyc++;
            if (done) begin
                lat = i - 1;
                break;
            end
            if (hi !== hi0 || lo !== lo0) partial = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = NOP; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got busy=%b done=%b dz=%b expected 000", busy, done, div_zero);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0", hi, lo);
        end
        checks++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat, bc; logic dz1, part;
        run_op(MULT, 32'hFFFFFFFE, 32'h00000003, lat, bc, dz1, part);
        if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", lat); end
        checks++;
        if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL mult_result: got %h_%h expected FFFFFFFF_FFFFFFFA", hi, lo);
        end
        checks++;
        if (part !== 1'b0) begin errors++; $display("FAIL mult_no_partial: hi/lo changed before done"); end
        checks++;
        @(negedge clk);
        if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
        checks++;
    endtask

    task automatic test_mult_unsigned();
        int lat, bc; logic dz1, part;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, dz1, part);
        if (lat !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++; $display("FAIL multu_result: got lat=%0d %h_%h expected 33 FFFFFFFE_00000001", lat, hi, lo);
        end
        checks++;
        @(negedge clk);
        run_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, dz1, part);
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'h00000001) begin
            errors++; $display("FAIL mult_neg1sq: got lat=%0d %h_%h expected 33 00000000_00000001", lat, hi, lo);
        end
        checks++;
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat, bc; logic dz1, part;
        run_op(DIV, 32'hFFFFFFF9, 32'h00000002, lat, bc, dz1, part);
        if (lat !== 33 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL div_signed: got lat=%0d lo=%h hi=%h expected 33 FFFFFFFD FFFFFFFF", lat, lo, hi);
        end
        checks++;
        @(negedge clk);
        run_op(DIVU, 32'h00000007, 32'h00000002, lat, bc, dz1, part);
        if (lo !== 32'h3 || hi !== 32'h1) begin
            errors++; $display("FAIL divu: got lo=%h hi=%h expected 00000003 00000001", lo, hi);
        end
        checks++;
        if (div_zero !== 1'b0) begin errors++; $display("FAIL divu_dz: got %b expected 0", div_zero); end
        checks++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic dz1, part;
        run_op(DIV, 32'h00000005, 32'h00000000, lat, bc, dz1, part);
        if (lat !== 33 || lo !== 32'hFFFFFFFF || hi !== 32'h00000005) begin
            errors++; $display("FAIL div_by_zero: got lat=%0d lo=%h hi=%h expected 33 FFFFFFFF 00000005", lat, lo, hi);
        end
        checks++;
        if (div_zero !== 1'b1) begin errors++; $display("FAIL div_zero_flag: got %b expected 1", div_zero); end
        checks++;
        // Start issued in the done cycle itself
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc, dz1, part);
        if (dz1 !== 1'b0) begin errors++; $display("FAIL dz_clear_on_start: got %b expected 0", dz1); end
        checks++;
        if (lat !== 33 || lo !== 32'h80000000 || hi !== 32'h0) begin
            errors++; $display("FAIL div_minneg: got lat=%0d lo=%h hi=%h expected 33 80000000 00000000", lat, lo, hi);
        end
        checks++;
        if (div_zero !== 1'b0) begin errors++; $display("FAIL div_minneg_dz: got %b expected 0", div_zero); end
        checks++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] lo0;
        int pulses;
        logic seen;
        start = 1'b1; op = MTHI; a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        if (done !== 1'b1 || busy !== 1'b0 || hi !== 32'h12345678) begin
            errors++; $display("FAIL mthi: got done=%b busy=%b hi=%h expected 1 0 12345678", done, busy, hi);
        end
        checks++;
        lo0 = lo;
        start = 1'b1; op = MULT; a = 32'h2; b = 32'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h12345678 || lo !== lo0) begin
            errors++; $display("FAIL flush_abort: got busy=%b done=%b hi=%h lo=%h expected 0 0 12345678 %h", busy, done, hi, lo, lo0);
        end
        checks++;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        if (pulses !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", pulses); end
        checks++;
        // Start while busy must be ignored
        start = 1'b1; op = MULTU; a = 32'h3; b = 32'h4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MTLO; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        if (done !== 1'b0 || lo !== lo0 || busy !== 1'b1) begin
            errors++; $display("FAIL start_while_busy: got done=%b busy=%b lo=%h expected 0 1 %h", done, busy, lo, lo0);
        end
        checks++;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        if (seen !== 1'b1 || lo !== 32'h0000000C || hi !== 32'h0) begin
            errors++; $display("FAIL multu_after_ignored: got done_seen=%b hi=%h lo=%h expected 1 00000000 0000000C", seen, hi, lo);
        end
        checks++;
        @(negedge clk);
        // Flush and start together in IDLE: flush wins
        start = 1'b1; op = MTLO; a = 32'hAAAA5555; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (done !== 1'b0 || lo !== 32'h0000000C || busy !== 1'b0) begin
            errors++; $display("FAIL flush_start_idle: got done=%b busy=%b lo=%h expected 0 0 0000000C", done, busy, lo);
        end
        checks++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, bc; logic dz1, part;
        start = 1'b1; op = MTHI; a = 32'h55555555;
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'h00000064; b = 32'h00000007;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(MULTU, 32'h3, 32'h4, lat, bc, dz1, part);
        if (lat !== 33 || lo !== 32'h0000000C || hi !== 32'h0) begin
            errors++; $display("FAIL post_reset_multu: got lat=%0d hi=%h lo=%h expected 33 00000000 0000000C", lat, hi, lo);
        end
        checks++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mult_unsigned();
        test_div();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
